common_dffram_2w_nr_cv: RTL and testbench

Next-generation DFF-based RAM. Two write ports with per-bit write enables. RAM_READ_PORTS independent read ports. Per-entry valid bits with a single-cycle flash clear. Read timing (combinational or registered) and read/write collision mode (read-first or write-first) are selectable at elaboration. Intended for small tables (BTB/TLB tags, rename maps, scoreboards) in the core and cache control paths.

---
 rtl/common_dffram_2w_nr_cv_pkg.sv | 12 +
 rtl/common_dffram_wmerge.sv | 34 +++
 rtl/common_dffram_2w_nr_cv.sv | 141 ++++++++++++++
 tb/tb_common_dffram_2w_nr_cv.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/common_dffram_2w_nr_cv_pkg.sv
// Mode encodings shared by the DFF RAM and anything that configures it.
package common_dffram_2w_nr_cv_pkg;

   // Read timing
   localparam int RD_COMB = 0;
   localparam int RD_REG  = 1;

   // Read/write collision behaviour
   localparam int WR_READ_FIRST  = 0;
   localparam int WR_WRITE_FIRST = 1;

endpackage

// File: rtl/common_dffram_wmerge.sv
// Per-entry next-state merge for the two write ports of the DFF RAM.
// Port 1 is applied after port 0, so it wins on any bit both ports enable.
module common_dffram_wmerge #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] cur_data,
   input  logic              cur_vld,
   input  logic              hit0,
   input  logic [DATA_W-1:0] be0,
   input  logic [DATA_W-1:0] data0,
   input  logic              hit1,
   input  logic [DATA_W-1:0] be1,
   input  logic [DATA_W-1:0] data1,
   input  logic              clear,
   output logic [DATA_W-1:0] nxt_data,
   output logic              nxt_vld,
   output logic              wr_hit
);

   logic [DATA_W-1:0] msk0;
   logic [DATA_W-1:0] msk1;

   // Bit-enable merge: port 0 first, then port 1; clear loses to any real write
   always_comb begin
      msk0     = hit0 ? be0 : '0;
      msk1     = hit1 ? be1 : '0;
      nxt_data = cur_data;
      nxt_data = (nxt_data & ~msk0) | (data0 & msk0);
      nxt_data = (nxt_data & ~msk1) | (data1 & msk1);
      wr_hit   = (|msk0) | (|msk1);
      nxt_vld  = wr_hit | (cur_vld & ~clear);
   end

endmodule

// File: rtl/common_dffram_2w_nr_cv.sv
// DFF-based RAM: two bit-enabled write ports, N independent read ports,
// per-entry valid bits with flash clear, selectable read timing/forwarding.
module common_dffram_2w_nr_cv
   import common_dffram_2w_nr_cv_pkg::*;
#(
   parameter int RAM_DATA_WIDTH = 8,
   parameter int RAM_ADDR_WIDTH = 3,
   parameter int RAM_READ_PORTS = 2,
   parameter logic [(1<<RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0,
   parameter int READ_REGISTERED = RD_COMB,
   parameter int WRITE_FORWARD   = WR_READ_FIRST
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   clear,
   input  logic                                   wen0,
   input  logic [RAM_ADDR_WIDTH-1:0]              waddr0,
   input  logic [RAM_DATA_WIDTH-1:0]              wbe0,
   input  logic [RAM_DATA_WIDTH-1:0]              wdata0,
   input  logic                                   wen1,
   input  logic [RAM_ADDR_WIDTH-1:0]              waddr1,
   input  logic [RAM_DATA_WIDTH-1:0]              wbe1,
   input  logic [RAM_DATA_WIDTH-1:0]              wdata1,
   input  logic [RAM_READ_PORTS-1:0]              ren,
   input  logic [RAM_READ_PORTS*RAM_ADDR_WIDTH-1:0] raddr,
   output logic [RAM_READ_PORTS*RAM_DATA_WIDTH-1:0] rdata,
   output logic [RAM_READ_PORTS-1:0]              rvalid
);

   localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
   localparam int DW    = RAM_DATA_WIDTH;
   localparam int AW    = RAM_ADDR_WIDTH;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [DEPTH-1:0] wr_hit;

   // ---- Write side: merged next state per entry, shared by storage and bypass
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(i);
      logic hit0;
      logic hit1;

      assign hit0 = wen0 && (waddr0 == IDX);
      assign hit1 = wen1 && (waddr1 == IDX);

      common_dffram_wmerge #(
         .DATA_W (DW)
      ) u_wmerge (
         .cur_data (mem_q[i]),
         .cur_vld  (vld_q[i]),
         .hit0     (hit0),
         .be0      (wbe0),
         .data0    (wdata0),
         .hit1     (hit1),
         .be1      (wbe1),
         .data1    (wdata1),
         .clear    (clear),
         .nxt_data (mem_d[i]),
         .nxt_vld  (vld_d[i]),
         .wr_hit   (wr_hit[i])
      );

      // Entry storage: loads only when some port actually writes a bit here
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mem_q[i] <= RAM_RESET_VALUE[DW*i +: DW];
         end else if (wr_hit[i]) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Valid bits: clear and writes are already folded into vld_d
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // ---- Read side: one independent mux (and optional register) per port
   for (genvar k = 0; k < RAM_READ_PORTS; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] sel_data;
      logic          sel_vld;

      assign ra = raddr[k*AW +: AW];

      // Choose stored state (read-first) or merged next state (write-first)
      always_comb begin
         sel_data = mem_q[ra];
         sel_vld  = vld_q[ra];
         if (WRITE_FORWARD == WR_WRITE_FIRST) begin
            sel_data = mem_d[ra];
            sel_vld  = vld_d[ra];
         end
      end

      if (READ_REGISTERED == RD_REG) begin : g_reg
         logic [DW-1:0] rdata_d;
         logic [DW-1:0] rdata_q;
         logic          rvalid_d;
         logic          rvalid_q;

         // Output register loads on ren, otherwise holds
         always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = rvalid_q;
            if (ren[k]) begin
               rdata_d  = sel_data;
               rvalid_d = sel_vld;
            end
         end

         // Registered read output
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rdata_q  <= rdata_d;
               rvalid_q <= rvalid_d;
            end
         end

         assign rdata[k*DW +: DW] = rdata_q;
         assign rvalid[k]         = rvalid_q;
      end else begin : g_comb
         // Read enable has no meaning for a combinational read port
         logic unused_ren;
         assign unused_ren        = ren[k];
         assign rdata[k*DW +: DW] = sel_data;
         assign rvalid[k]         = sel_vld;
      end
   end

endmodule

// File: tb/tb_common_dffram_2w_nr_cv.sv
// Bench for the DFF RAM: four instances cover every read-timing/forwarding
// mode, all driven by the same stimulus and checked against one array model.
module tb_common_dffram_2w_nr_cv;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NP = 3;
   localparam int DEPTH = 1 << AW;
   localparam logic [DEPTH*DW-1:0] RV = 64'h0000_0000_A500_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          wen0, wen1;
   logic [AW-1:0] waddr0, waddr1;
   logic [DW-1:0] wbe0, wbe1, wdata0, wdata1;
   logic [NP-1:0] ren;
   logic [NP*AW-1:0] raddr;

   logic [NP*DW-1:0] rdata_m [4];
   logic [NP-1:0]    rvalid_m [4];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model
   logic [DW-1:0] mdl_mem [DEPTH];
   logic          mdl_vld [DEPTH];
   logic [DW-1:0] mdl_rd  [4][NP];
   logic          mdl_rv  [4][NP];

   always #5 clk = ~clk;

   // m = {READ_REGISTERED, WRITE_FORWARD}
   for (genvar m = 0; m < 4; m++) begin : g_dut
      common_dffram_2w_nr_cv #(
         .RAM_DATA_WIDTH  (DW),
         .RAM_ADDR_WIDTH  (AW),
         .RAM_READ_PORTS  (NP),
         .RAM_RESET_VALUE (RV),
         .READ_REGISTERED (m / 2),
         .WRITE_FORWARD   (m % 2)
      ) u_dut (
         .clk    (clk),
         .reset  (reset),
         .clear  (clear),
         .wen0   (wen0),
         .waddr0 (waddr0),
         .wbe0   (wbe0),
         .wdata0 (wdata0),
         .wen1   (wen1),
         .waddr1 (waddr1),
         .wbe1   (wbe1),
         .wdata1 (wdata1),
         .ren    (ren),
         .raddr  (raddr),
         .rdata  (rdata_m[m]),
         .rvalid (rvalid_m[m])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [DW-1:0] n_data(input int a);
      logic [DW-1:0] d;
      d = mdl_mem[a];
      if (wen0 && waddr0 == a) for (int b = 0; b < DW; b++) if (wbe0[b]) d[b] = wdata0[b];
      if (wen1 && waddr1 == a) for (int b = 0; b < DW; b++) if (wbe1[b]) d[b] = wdata1[b];
      return d;
   endfunction

   function automatic logic n_vld(input int a);
      logic v;
      v = clear ? 1'b0 : mdl_vld[a];
      if (wen0 && waddr0 == a && wbe0 != 0) v = 1'b1;
      if (wen1 && waddr1 == a && wbe1 != 0) v = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) begin
         mdl_mem[a] = RV[a*DW +: DW];
         mdl_vld[a] = 1'b0;
      end
      for (int m = 0; m < 4; m++)
         for (int k = 0; k < NP; k++) begin
            mdl_rd[m][k] = '0;
            mdl_rv[m][k] = 1'b0;
         end
   endtask

   task automatic check_all();
      int a;
      logic [DW-1:0] ed;
      logic          ev;
      for (int m = 0; m < 4; m++)
         for (int k = 0; k < NP; k++) begin
            a = int'(raddr[k*AW +: AW]);
            if (m == 0) begin ed = mdl_mem[a]; ev = mdl_vld[a]; end
            else if (m == 1) begin ed = n_data(a); ev = n_vld(a); end
            else begin ed = mdl_rd[m][k]; ev = mdl_rv[m][k]; end
            chk($sformatf("mode%0d_rdata%0d", m, k), 32'(rdata_m[m][k*DW +: DW]), 32'(ed));
            chk($sformatf("mode%0d_rvalid%0d", m, k), 32'(rvalid_m[m][k]), 32'(ev));
         end
   endtask

   // Called at a falling edge with inputs already driven; ends at next falling edge.
   task automatic step();
      logic [DW-1:0] nd [DEPTH];
      logic          nv [DEPTH];
      int a;
      #1 check_all();
      @(posedge clk);
      for (int m = 2; m < 4; m++)
         for (int k = 0; k < NP; k++)
            if (ren[k]) begin
               a = int'(raddr[k*AW +: AW]);
               mdl_rd[m][k] = (m == 3) ? n_data(a) : mdl_mem[a];
               mdl_rv[m][k] = (m == 3) ? n_vld(a)  : mdl_vld[a];
            end
      for (int i = 0; i < DEPTH; i++) begin nd[i] = n_data(i); nv[i] = n_vld(i); end
      for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = nd[i]; mdl_vld[i] = nv[i]; end
      @(negedge clk);
   endtask

   task automatic idle();
      wen0 = 0; wen1 = 0; clear = 0;
      waddr0 = 0; waddr1 = 0; wbe0 = 0; wbe1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic set_raddr(input int a0, input int a1, input int a2);
      raddr = {AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] be, input logic [DW-1:0] d);
      if (p == 0) begin wen0 = 1; waddr0 = AW'(a); wbe0 = be; wdata0 = d; end
      else        begin wen1 = 1; waddr1 = AW'(a); wbe1 = be; wdata1 = d; end
   endtask

   initial begin
      reset = 1'b1; idle(); ren = '0; set_raddr(0, 0, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // Reset image visible, valid low
      ren = '1; set_raddr(3, 3, 3);
      step();
      chk("rst_comb_data", 32'(rdata_m[0][7:0]), 32'hA5);
      chk("rst_comb_vld", 32'(rvalid_m[0][0]), 0);
      chk("rst_reg_data", 32'(rdata_m[2][7:0]), 32'hA5);

      // Reset during a write discards the write
      wr(0, 3, 8'hFF, 8'hFF);
      #2 reset = 1'b1;
      model_reset();
      @(posedge clk); @(negedge clk);
      reset = 1'b0; idle();
      step();
      chk("rst_midwrite", 32'(rdata_m[0][7:0]), 32'hA5);

      // Full write then partial bit-enable write
      wr(0, 5, 8'hFF, 8'h12); step(); idle();
      set_raddr(5, 5, 5); step();
      chk("wr_full", 32'(rdata_m[0][7:0]), 32'h12);
      chk("wr_full_vld", 32'(rvalid_m[0][0]), 1);
      wr(0, 5, 8'h0F, 8'hFF); step(); idle(); step();
      chk("wr_partial", 32'(rdata_m[0][7:0]), 32'h1F);

      // Port collisions
      wr(0, 2, 8'hFF, 8'hAA); wr(1, 2, 8'hFF, 8'h55); step(); idle();
      set_raddr(2, 2, 2); step();
      chk("coll_p1_wins", 32'(rdata_m[0][7:0]), 32'h55);
      wr(0, 2, 8'hF0, 8'hAA); wr(1, 2, 8'h0F, 8'h55); step(); idle(); step();
      chk("coll_merge", 32'(rdata_m[0][7:0]), 32'hA5);

      // Flash clear together with a write
      wr(0, 1, 8'hFF, 8'h44); wr(1, 4, 8'hFF, 8'h10); step(); idle();
      clear = 1; wr(0, 4, 8'hFF, 8'h33); step(); idle();
      set_raddr(1, 4, 0); step();
      chk("clr_vld1", 32'(rvalid_m[0][0]), 0);
      chk("clr_vld4", 32'(rvalid_m[0][1]), 1);
      chk("clr_data1", 32'(rdata_m[0][7:0]), 32'h44);
      chk("clr_data4", 32'(rdata_m[0][15:8]), 32'h33);

      // Same-cycle read/write collision in each mode
      wr(0, 6, 8'hFF, 8'h11); step(); idle();
      set_raddr(6, 6, 6); ren = '1; wr(0, 6, 8'hFF, 8'h77);
      #1;
      chk("rw_comb_rf", 32'(rdata_m[0][7:0]), 32'h11);
      chk("rw_comb_wf", 32'(rdata_m[1][7:0]), 32'h77);
      step();
      chk("rw_reg_rf", 32'(rdata_m[2][7:0]), 32'h11);
      chk("rw_reg_wf", 32'(rdata_m[3][7:0]), 32'h77);
      idle();

      // Per-port read enable on registered ports
      set_raddr(7, 7, 7); step();
      wr(0, 0, 8'hFF, 8'h9C); step(); idle();
      set_raddr(0, 0, 0); ren = 3'b101; step();
      chk("ren_p0", 32'(rdata_m[2][7:0]), 32'h9C);
      chk("ren_p1_hold", 32'(rdata_m[2][15:8]), 32'h00);
      chk("ren_p2", 32'(rdata_m[2][23:16]), 32'h9C);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         wen0 = 1'($urandom); wen1 = 1'($urandom);
         waddr0 = AW'($urandom); waddr1 = AW'($urandom_range(0, 3) == 0 ? waddr0 : AW'($urandom));
         for (int p = 0; p < 2; p++) begin
            logic [DW-1:0] be;
            case ($urandom_range(0, 3))
               0: be = '0;
               1: be = '1;
               default: be = DW'($urandom);
            endcase
            if (p == 0) wbe0 = be; else wbe1 = be;
         end
         wdata0 = DW'($urandom); wdata1 = DW'($urandom);
         clear = ($urandom_range(0, 15) == 0);
         ren = NP'($urandom);
         raddr = (NP*AW)'($urandom);
         step();
      end

      idle(); ren = '1; step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
